// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Package name pipe_pkg is kept for compatibility with existing importers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // EX/MEM is checked first so the youngest producer wins; r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] exmem_rd,
    input logic       exmem_regwrite,
    input logic [4:0] memwb_rd,
    input logic       memwb_regwrite
  );
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src))
      return FWD_MEM;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage forwarding select generation; purely combinational.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] idex_rs,
  input  logic [4:0] idex_rt,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  always_comb begin
    fwd_a = fwd_sel(idex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    fwd_b = fwd_sel(idex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, bubbles, forwarding, dmem wait FSM.
// Define PIPE_HAZARD_CTRL_PERF_EN to enable the stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              load_use;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt >= WCNT_W'(WAIT_MAX)) begin
          state_nxt = ERR;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    mem_err      = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          // A taken branch flushes the stalled instruction anyway, so it overrides load-use.
          pc_en      = !(load_use && !branch_taken);
          ifid_en    = !(load_use && !branch_taken);
          ifid_flush = branch_taken;
          idex_flush = branch_taken || load_use;
        end
        MEM_WAIT: memwb_bubble = 1'b1;
        ERR: begin
          memwb_bubble = 1'b1;
          mem_err      = 1'b1;
        end
        default: memwb_bubble = 1'b1;
      endcase
    end
  end

  fwd_unit u_fwd (
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .fwd_a          (fwd_a_raw),
    .fwd_b          (fwd_b_raw)
  );

  assign fwd_a = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b = reset ? FWD_RF : fwd_b_raw;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)     stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random stimulus vs a reference model.
module tb_pipe_hazard_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
  logic             idex_memread, exmem_regwrite, memwb_regwrite;
  logic             branch_taken, dmem_req, dmem_ack;
  logic             pc_en, ifid_en, idex_en, exmem_en;
  logic             ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memread(idex_memread), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 running, 1 waiting on memory, 2 error.
  int               mode = 0;
  int               waited = 0;
  bit               cnt_known = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;
  bit               e_pc_en, e_ifid_flush;
  bit               perf_en;

  initial begin
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    perf_en = 1;
`else
    perf_en = 0;
`endif
  end

  function automatic logic [1:0] ref_fwd(input int src, input int er, input bit ew,
                                         input int mr, input bit mw);
    if (ew && er != 0 && er == src) return 2'b10;
    if (mw && mr != 0 && mr == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_all();
    bit lu, br, stall;
    bit e_ifid_en, e_idex_en, e_exmem_en, e_idex_flush, e_bubble, e_err;
    logic [1:0] e_fa, e_fb;
    lu = idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    br = branch_taken;
    e_fa = ref_fwd(idex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    e_fb = ref_fwd(idex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    if (reset) begin
      {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = '0;
      {e_ifid_flush, e_idex_flush, e_bubble, e_err} = '0;
      e_fa = 2'b00;
      e_fb = 2'b00;
    end else if (mode != 0) begin
      {e_pc_en, e_ifid_en, e_idex_en, e_exmem_en} = '0;
      {e_ifid_flush, e_idex_flush} = '0;
      e_bubble = 1;
      e_err = (mode == 2);
    end else begin
      stall = lu && !br;
      e_pc_en = !stall;
      e_ifid_en = !stall;
      e_idex_en = 1;
      e_exmem_en = 1;
      e_ifid_flush = br;
      e_idex_flush = br || lu;
      e_bubble = 0;
      e_err = 0;
    end
    check("pc_en", pc_en, e_pc_en);
    check("ifid_en", ifid_en, e_ifid_en);
    check("idex_en", idex_en, e_idex_en);
    check("exmem_en", exmem_en, e_exmem_en);
    check("ifid_flush", ifid_flush, e_ifid_flush);
    check("idex_flush", idex_flush, e_idex_flush);
    check("memwb_bubble", memwb_bubble, e_bubble);
    check("mem_err", mem_err, e_err);
    check("fwd_a", fwd_a, e_fa);
    check("fwd_b", fwd_b, e_fb);
    if (cnt_known) begin
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
    end
  endtask

  task automatic update_model();
    if (reset) begin
      mode = 0;
      waited = 0;
      m_stall = '0;
      m_flush = '0;
      cnt_known = 1;
    end else begin
      if (perf_en && !e_pc_en) m_stall += 1;
      if (perf_en && e_ifid_flush) m_flush += 1;
      case (mode)
        0: if (dmem_req && !dmem_ack) begin mode = 1; waited = 1; end
        1: begin
          if (dmem_ack) mode = 0;
          else if (waited >= WAIT_MAX) mode = 2;
          else waited++;
        end
        default: mode = 2;
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    {ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd} = '0;
    {idex_memread, exmem_regwrite, memwb_regwrite} = '0;
    {branch_taken, dmem_req, dmem_ack} = '0;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
    step();

    // Load-use stall for one cycle, then none when idex_rt is r0.
    idex_memread = 1; idex_rt = 5; ifid_rs = 5;
    step();
    idex_memread = 0;
    step();
    check("lu_release_pc_en", pc_en, 1'b1);
    idex_memread = 1; idex_rt = 0; ifid_rs = 5;
    step();
    check("lu_r0_pc_en", pc_en, 1'b1);
    idle();

    // Double forward: EX/MEM wins, then MEM/WB once EX/MEM stops writing.
    exmem_rd = 7; memwb_rd = 7; exmem_regwrite = 1; memwb_regwrite = 1; idex_rs = 7;
    step();
    check("dfwd_a_mem", fwd_a, 2'b10);
    exmem_regwrite = 0;
    step();
    check("dfwd_a_wb", fwd_a, 2'b01);
    idle();

    // Memory wait of three cycles.
    reset = 1; step(); reset = 0;
    dmem_req = 1; dmem_ack = 0;
    step();
    step();
    step();
    dmem_ack = 1;
    step();
    dmem_req = 0; dmem_ack = 0;
    step();
    check("wait_run_pc_en", pc_en, 1'b1);
    check("wait_stall_cnt", stall_cnt, perf_en ? 32'd3 : 32'd0);

    // Timeout into the sticky error state, then reset out of it.
    dmem_req = 1;
    for (int unsigned i = 0; i < 8; i++) step();
    check("timeout_err", mem_err, 1'b1);
    dmem_req = 0;
    reset = 1; step(); reset = 0;
    step();
    check("err_cleared", mem_err, 1'b0);

    // Branch together with load-use.
    reset = 1; step(); reset = 0;
    idex_memread = 1; idex_rt = 5; ifid_rs = 5; branch_taken = 1;
    step();
    check("br_lu_flush_cnt", flush_cnt, perf_en ? 32'd1 : 32'd0);
    idle();

    // Reset in the second wait cycle.
    dmem_req = 1;
    step();
    step();
    reset = 1;
    step();
    reset = 0; dmem_req = 0;
    step();
    check("midwait_pc_en", pc_en, 1'b1);

    // Random traffic with occasional resets.
    for (int unsigned i = 0; i < 1000; i++) begin
      reset          = ($urandom_range(0, 39) == 0);
      ifid_rs        = 5'($urandom_range(0, 7));
      ifid_rt        = 5'($urandom_range(0, 7));
      idex_rs        = 5'($urandom_range(0, 7));
      idex_rt        = 5'($urandom_range(0, 7));
      exmem_rd       = 5'($urandom_range(0, 7));
      memwb_rd       = 5'($urandom_range(0, 7));
      idex_memread   = 1'($urandom_range(0, 1));
      exmem_regwrite = 1'($urandom_range(0, 1));
      memwb_regwrite = 1'($urandom_range(0, 1));
      branch_taken   = ($urandom_range(0, 4) == 0);
      dmem_req       = ($urandom_range(0, 5) == 0);
      dmem_ack       = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
